// File: rtl/inst_sched_arbiter.sv
// Round-robin scheduler sharing one controller instruction port among NUM_REQ sources.
// Issues one instruction at a time and waits for completion or a watchdog timeout.
package inst_sched_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  count;
    logic [15:0] addr;
  } instruction_t;
endpackage

module inst_sched_arbiter
  import inst_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  instruction_t        req_inst [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_ready,
  output instruction_t        inst,
  output logic                inst_valid,
  input  logic                inst_exec_begins,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned     TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt, winner;
  logic [ID_W:0]     cand;
  logic              found, take, tmo_hit;
  logic [TMR_W-1:0]  timer;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  assign take       = (state == IDLE) && found;
  assign tmo_hit    = (timer == TMR_LAST);
  assign busy       = (state != IDLE);
  assign rr_ptr_nxt = (winner == LAST_ID) ? '0 : winner + ID_W'(1);

  // Accept handshake is combinational so the transfer lands in the same cycle
  always_comb begin
    req_ready = '0;
    if (take && !rst) req_ready = NUM_REQ'(1) << winner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (take) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (inst_exec_begins || tmo_hit) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Datapath: latched instruction, grant bookkeeping and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      timer       <= '0;
      inst        <= '0;
      inst_valid  <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      inst_valid <= take;
      if (take) begin
        inst     <= req_inst[winner];
        grant_id <= winner;
        rr_ptr   <= rr_ptr_nxt;
      end
      if (state == ISSUE)          timer <= '0;
      else if (state == WAIT_DONE) timer <= timer + TMR_W'(1);
      // A completion arriving on the last watchdog cycle still counts as done
      if (state == WAIT_DONE && !inst_exec_begins && tmo_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_sched_arbiter.sv
// Randomized scoreboard bench for inst_sched_arbiter against a cycle-phase reference model.
module tb_inst_sched_arbiter;
  import inst_sched_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;
  localparam int unsigned IDW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  instruction_t       req_inst [N];
  logic [N-1:0]       req_ready;
  instruction_t       inst;
  logic               inst_valid;
  logic               inst_exec_begins;
  logic [IDW-1:0]     grant_id;
  logic               busy;
  logic               timeout_err;

  inst_sched_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_inst(req_inst),
    .req_ready(req_ready), .inst(inst), .inst_valid(inst_valid),
    .inst_exec_begins(inst_exec_begins), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    instruction_t   ins;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: age -1 = idle, 1 = issue cycle, >=2 = waiting (timer = age-2)
  int   age = -1;
  int   rr = 0;
  bit   err = 1'b0;
  int   done_at = 0;
  bit   accepted [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every issue strobe must match the oldest predicted grant
  always @(negedge clk) begin
    if (!rst && inst_valid === 1'b1) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_issue: got grant %0d with no prediction at %0t", grant_id, $time);
      end else begin
        mon_e = q.pop_front();
        chk("issue_grant_id", 64'(grant_id), 64'(mon_e.id));
        chk("issue_inst", 64'(inst), 64'(mon_e.ins));
      end
    end
  end

  // One clock: check registered outputs, drive new inputs, predict the next edge
  task automatic step(input int pv, input int drop, input int dmode);
    logic [N-1:0] exp_ready;
    bit           dn;
    int           win;
    @(negedge clk);
    chk("busy", 64'(busy), 64'(age != -1));
    chk("inst_valid", 64'(inst_valid), 64'(age == 1));
    chk("timeout_err", 64'(timeout_err), 64'(err));
    for (int i = 0; i < N; i++) begin
      if (!(req_valid[i] && !accepted[i] && $urandom_range(99) >= drop)) begin
        req_valid[i] = ($urandom_range(99) < pv);
        req_inst[i]  = instruction_t'($urandom);
      end
    end
    dn = 1'b0;
    if (age >= 2 && (age - 2) >= done_at) dn = 1'b1;
    else if (age < 2 && dmode == 0 && $urandom_range(9) == 0) dn = 1'b1;
    inst_exec_begins = dn;
    #1;
    exp_ready = '0;
    for (int i = 0; i < N; i++) accepted[i] = 1'b0;
    if (age == -1) begin
      win = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(rr + k) % N]) win = (rr + k) % N;
      if (win >= 0) begin
        exp_ready[win] = 1'b1;
        q.push_back(exp_t'{id: IDW'(win), ins: req_inst[win]});
        rr = (win + 1) % N;
        accepted[win] = 1'b1;
        age = 1;
        case (dmode)
          1:       done_at = 2;
          2:       done_at = 1000;
          3:       done_at = TMO - 1;
          default: done_at = $urandom_range(0, 6);
        endcase
      end
    end else if (age == 1) begin
      age = 2;
    end else begin
      if (dn) age = -1;
      else if (age - 2 == TMO - 1) begin
        err = 1'b1;
        age = -1;
      end else age++;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '1;
    inst_exec_begins = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_inst[i] = instruction_t'($urandom);
      accepted[i] = 1'b0;
    end
    #3;
    chk("rst_inst_valid", 64'(inst_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_timeout_err", 64'(timeout_err), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_inst", 64'(inst), 64'(0));
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    repeat (24)  step(100, 0, 1);
    repeat (400) step(40, 10, 0);
    repeat (150) step(30, 5, 2);
    repeat (100) step(50, 5, 3);
    repeat (300) step(60, 10, 0);

    // Asynchronous reset while an instruction is waiting for completion
    for (int c = 0; c < 40 && age < 4; c++) step(100, 0, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_inst_valid", 64'(inst_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_grant_id", 64'(grant_id), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    chk("midrst_timeout_err", 64'(timeout_err), 64'(0));
    chk("midrst_pending", 64'(q.size()), 64'(0));
    q.delete();
    age = -1;
    rr = 0;
    err = 1'b0;
    for (int i = 0; i < N; i++) accepted[i] = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) step(100, 0, 1);
    repeat (TMO + 8) step(0, 100, 1);
    chk("scoreboard_drain", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
